dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port word-addressed data memory (64 × 32-bit, combinational read, write on rising clk) between the CPU load/store port (m0) and a secondary requester such as a debug/display/DMA port (m1). Grants one access per cycle with round-robin fairness and a bounded ownership hold. It enforces the memory's address window and returns registered read data with a one-cycle valid strobe. Sits between the requesters and the data memory's `we/a/wd/rd` pins.

## Interface
- `DW`, 32, data width
- `AW`, 32, byte-address width
- `MEM_BYTES`, 256, legal byte window; accesses with `addr >= MEM_BYTES` are out of range
- `MAX_HOLD`, 4, max consecutive grants to one owner while the other requester waits (≥1)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `mN_req` in 1 (N=0,1): access request, level
- `mN_we` in 1: 1=write, 0=read
- `mN_addr` in AW: byte address; bits [1:0] ignored
- `mN_wdata` in DW: write data
- `mN_gnt` out 1: combinational; access performed this cycle
- `mN_rvalid` out 1: registered; read data valid (one cycle)
- `mN_rdata` out DW: registered read data
- `mN_err` out 1: registered; one-cycle pulse, out-of-range access
- `mem_we` out 1, `mem_a` out AW, `mem_wd` out DW: to memory
- `mem_rd` in DW: from memory (combinational)

## Operation
- State: `own` ∈ {NONE, M0, M1}, `hold_cnt` (grants issued to current owner, saturating at MAX_HOLD), `last` (last granted port).
- Winner selection each cycle:
  - own=Mx, mx_req=1, and (other idle or hold_cnt < MAX_HOLD) → Mx.
  - Else, other requests → other; own←other, hold_cnt←1.
  - own=NONE, one request → that port; both → port ≠ `last`.
  - No request → no grant; own←NONE, hold_cnt←0.
  - Continued grant to the same owner: hold_cnt+1 (saturating).
- Granted port: `mN_gnt`=1, `mem_a`=addr, `mem_wd`=wdata. `mem_we`=we AND addr<MEM_BYTES. No grant: mem_a=0, mem_wd=0, mem_we=0.
- Read granted in cycle t: at edge t+1, `mN_rdata`←mem_rd (0 if out of range), `mN_rvalid`←1.
- Out-of-range read or write: write suppressed, `mN_err` pulses in cycle t+1. Writes never assert rvalid.
- Ungranted requester holds req/we/addr/wdata stable until gnt.

## Timing
- Grant latency 0 cycles (same cycle as req when winning); write committed at the granting edge; read latency 1 cycle.
- Back-to-back reads from one port: rvalid high every cycle, rdata tracks each.
- Reset (async assert): own=NONE, hold_cnt=0, last=M1 (m0 wins the first tie), all rvalid/err=0, all rdata=0. gnt and mem_we are 0 while reset_n=0. In-flight read responses are discarded.
- Ownership switches take effect the same cycle; no idle bubble.
- MAX_HOLD=1 degenerates to strict alternation under contention.

## Structure
- Package `dmem_arb_pkg`: owner enum (OWN_NONE, OWN_M0, OWN_M1), default MEM_BYTES, DW/AW constants.
- Sub-module `dmem_arb_pick`: combinational winner selection from (req vector, own, hold_cnt, last, MAX_HOLD). The top holds state registers, muxing, range check and response registers.

## Test plan
- After reset, m0 reads 0x0 and m1 reads 0x4 in the same cycle → m0_gnt first. m0_rvalid next cycle with RAM[0]; m1 granted next cycle, m1_rdata=RAM[1].
- m0 writes 0x8=0xDEADBEEF, then reads 0x8 → rdata=0xDEADBEEF one cycle after the read grant; m0_err stays 0.
- m1 writes 0x100=0x1234 → mem_we=0, m1_err pulses one cycle, RAM unchanged. m1 reads 0x100 → rdata=0, rvalid=1, err=1.
- MAX_HOLD=4, m0 and m1 both request continuously → grant sequence M0×4, M1×4, M0×4. With m1 idle, m0 is granted indefinitely.
- reset_n pulses low mid-stream while a read is outstanding → rvalid/err/rdata=0 immediately. After release, a tie goes to m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default sizes for the data-memory arbiter.
//   own_e          : current bus owner (none, CPU port m0, secondary port m1)
//   DMEM_*         : default data width, address width, legal byte window and
//                    ownership hold limit
//   port_to_own()  : maps a port index (0/1) to its owner encoding
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DMEM_DW        = 32;
    localparam int DMEM_AW        = 32;
    localparam int DMEM_MEM_BYTES = 256;
    localparam int DMEM_MAX_HOLD  = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

    function automatic own_e port_to_own(input logic port);
        return port ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner selection for the two-port data-memory arbiter.
//   i_req       : request vector, bit 0 = m0, bit 1 = m1
//   i_own       : current owner
//   i_hold_cnt  : grants already issued to the current owner (saturating)
//   i_last      : last granted port (0 = m0, 1 = m1), breaks ties when idle
//   o_win_vld   : some port wins this cycle
//   o_win_id    : winning port index
//   o_keep      : winner is the current owner continuing its tenure
// ---------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_HOLD = DMEM_MAX_HOLD,
    parameter int HW       = 3
) (
    input  logic [1:0]    i_req,
    input  own_e          i_own,
    input  logic [HW-1:0] i_hold_cnt,
    input  logic          i_last,
    output logic          o_win_vld,
    output logic          o_win_id,
    output logic          o_keep
);

    localparam logic [HW-1:0] HOLD_MAX_W = HW'(MAX_HOLD);

    logic w_hold_left;
    assign w_hold_left = (i_hold_cnt < HOLD_MAX_W);

    always_comb begin
        o_win_vld = 1'b0;
        o_win_id  = 1'b0;
        o_keep    = 1'b0;
        // The owner keeps the memory while it asks, unless the other side is
        // waiting and the owner has used up its hold budget.
        if (i_own == OWN_M0 && i_req[0] && (!i_req[1] || w_hold_left)) begin
            o_win_vld = 1'b1;
            o_win_id  = 1'b0;
            o_keep    = 1'b1;
        end else if (i_own == OWN_M1 && i_req[1] && (!i_req[0] || w_hold_left)) begin
            o_win_vld = 1'b1;
            o_win_id  = 1'b1;
            o_keep    = 1'b1;
        end else if (i_own == OWN_M0 && i_req[1]) begin
            o_win_vld = 1'b1;
            o_win_id  = 1'b1;
        end else if (i_own == OWN_M1 && i_req[0]) begin
            o_win_vld = 1'b1;
            o_win_id  = 1'b0;
        end else if (i_own == OWN_NONE && i_req != 2'b00) begin
            o_win_vld = 1'b1;
            // Tie from idle goes to whoever was not served last.
            o_win_id  = (i_req == 2'b11) ? ~i_last : i_req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port, word-addressed data memory (combinational read,
// write on rising clk) between the CPU load/store port m0 and a secondary
// port m1. One access per cycle, round-robin with a bounded ownership hold,
// byte-window range check and registered read responses.
//   clk, reset_n          : clock, asynchronous active-low reset
//   mN_req/we/addr/wdata  : request from port N (level, held until granted)
//   mN_gnt                : combinational, access performed this cycle
//   mN_rvalid/mN_rdata    : registered read response, one cycle after grant
//   mN_err                : registered one-cycle pulse for out-of-range access
//   mem_we/mem_a/mem_wd   : memory write enable, byte address, write data
//   mem_rd                : memory read data (combinational)
//   o_dbg_own             : current owner state
//   o_dbg_hold_cnt        : grants issued to current owner
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW        = DMEM_DW,
    parameter int AW        = DMEM_AW,
    parameter int MEM_BYTES = DMEM_MEM_BYTES,
    parameter int MAX_HOLD  = DMEM_MAX_HOLD
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         m0_req,
    input  logic                         m0_we,
    input  logic [AW-1:0]                m0_addr,
    input  logic [DW-1:0]                m0_wdata,
    output logic                         m0_gnt,
    output logic                         m0_rvalid,
    output logic [DW-1:0]                m0_rdata,
    output logic                         m0_err,
    input  logic                         m1_req,
    input  logic                         m1_we,
    input  logic [AW-1:0]                m1_addr,
    input  logic [DW-1:0]                m1_wdata,
    output logic                         m1_gnt,
    output logic                         m1_rvalid,
    output logic [DW-1:0]                m1_rdata,
    output logic                         m1_err,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_a,
    output logic [DW-1:0]                mem_wd,
    input  logic [DW-1:0]                mem_rd,
    output own_e                         o_dbg_own,
    output logic [$clog2(MAX_HOLD+1)-1:0] o_dbg_hold_cnt
);

    localparam int              HW         = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX_W = HW'(MAX_HOLD);
    localparam logic [AW-1:0]   MEM_LIMIT  = AW'(MEM_BYTES);

    // Handshake: mN_req acts as valid and mN_gnt as ready. A transfer happens
    // in the cycle where both are high; until then the requester keeps
    // req/we/addr/wdata stable. gnt depends combinationally on req and state.

    own_e            r_own;
    logic [HW-1:0]   r_hold;
    logic            r_last;
    logic [1:0]      r_rvalid;
    logic [1:0]      r_err;
    logic [1:0][DW-1:0] r_rdata;

    logic [1:0]      w_req;
    logic [1:0]      w_we;
    logic [1:0]      w_inr;
    logic [1:0]      w_gnt;
    logic            w_win_vld;
    logic            w_win_id;
    logic            w_keep;
    logic            w_any;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;

    assign w_req    = {m1_req, m0_req};
    assign w_we     = {m1_we, m0_we};
    assign w_inr[0] = (m0_addr < MEM_LIMIT);
    assign w_inr[1] = (m1_addr < MEM_LIMIT);

    dmem_arb_pick #(
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) u_pick (
        .i_req      (w_req),
        .i_own      (r_own),
        .i_hold_cnt (r_hold),
        .i_last     (r_last),
        .o_win_vld  (w_win_vld),
        .o_win_id   (w_win_id),
        .o_keep     (w_keep)
    );

    // Grants are forced low while reset is asserted so nothing reaches memory.
    assign w_any    = w_win_vld & reset_n;
    assign w_gnt[0] = w_any & ~w_win_id;
    assign w_gnt[1] = w_any &  w_win_id;

    assign w_sel_addr  = w_win_id ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_win_id ? m1_wdata : m0_wdata;

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];
    assign mem_a  = w_any ? w_sel_addr  : '0;
    assign mem_wd = w_any ? w_sel_wdata : '0;
    // Out-of-window writes are dropped here; the requester sees err instead.
    assign mem_we = w_any & w_we[w_win_id] & w_inr[w_win_id];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_own  <= OWN_NONE;
            r_hold <= '0;
            r_last <= 1'b1;
        end else if (!w_win_vld) begin
            r_own  <= OWN_NONE;
            r_hold <= '0;
        end else begin
            r_own  <= port_to_own(w_win_id);
            r_last <= w_win_id;
            if (w_keep)
                r_hold <= (r_hold == HOLD_MAX_W) ? r_hold : r_hold + 1'b1;
            else
                r_hold <= HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_rvalid[p] <= w_gnt[p] & ~w_we[p];
                r_err[p]    <= w_gnt[p] & ~w_inr[p];
                // rdata holds its last value between reads.
                if (w_gnt[p] & ~w_we[p])
                    r_rdata[p] <= w_inr[p] ? mem_rd : '0;
            end
        end
    end

    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_rdata[0];
    assign m1_rdata  = r_rdata[1];

    assign o_dbg_own      = r_own;
    assign o_dbg_hold_cnt = r_hold;

endmodule
